// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero deletion and LSB-first byte assembly.
// Abort detection is compiled in only when HDLC_RX_ABORT_DETECT_EN is defined.
module hdlc_rx_deframer #(
   parameter int unsigned ABORT_ONES = 7
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       RxEN,
   input  logic       Rx,
   output logic       Rx_FlagDetect,
   output logic       Rx_ValidFrame,
   output logic       Rx_AbortSignal,
   output logic [7:0] Rx_Data,
   output logic       Rx_DataValid,
   output logic       Rx_EndOfFrame,
   output logic       Rx_FrameError,
   output logic [1:0] RxState
);

   // Downstream has no ready: every strobe is valid for exactly one Clk cycle and must be taken then.
   typedef enum logic [1:0] {HUNT = 2'd0, OPEN = 2'd1, DATA = 2'd2} stateT;
   localparam logic [3:0] ABORT_CNT = 4'(ABORT_ONES);

   stateT      state, stateNext;
   logic [3:0] onesCnt, onesNext, fill;
   logic [7:0] delayLine, shiftReg;
   logic [2:0] bitCnt, bitCntAfter;
   logic       isFlag, isStuff, isAbort, accept, exitValid, exitBit, dataBit, byteDone, inFrame;
   logic       flagNext, abortNext, eofNext, errNext;

   assign onesNext = Rx ? ((onesCnt == ABORT_CNT) ? onesCnt : onesCnt + 4'd1) : 4'd0;
   assign isFlag   = RxEN && !Rx && (onesCnt == 4'd6);
   assign isStuff  = RxEN && !Rx && (onesCnt == 4'd5);
`ifdef HDLC_RX_ABORT_DETECT_EN
   assign isAbort  = RxEN && Rx && (onesCnt == ABORT_CNT - 4'd1);
`else
   assign isAbort  = 1'b0;
`endif
   assign accept   = RxEN && !isStuff && !isFlag && !isAbort;
   // The flag's closing 0 still pushes the oldest data bit out before the flush.
   assign exitValid   = (accept || isFlag) && (fill == 4'd8);
   assign exitBit     = delayLine[7];
   assign dataBit     = exitValid && (state != HUNT);
   assign byteDone    = dataBit && (bitCnt == 3'd7);
   assign bitCntAfter = dataBit ? bitCnt + 3'd1 : bitCnt;
   assign inFrame     = (state == DATA) || dataBit;
   assign RxState     = state;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= HUNT;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      if (isAbort)                         stateNext = HUNT;
      else if (isFlag)                     stateNext = OPEN;
      else if (dataBit && (state == OPEN)) stateNext = DATA;
   end

   always_comb begin
      flagNext  = isFlag;
      abortNext = isAbort && (state == DATA);
      eofNext   = isFlag && inFrame && (bitCntAfter == 3'd0);
      errNext   = isFlag && inFrame && (bitCntAfter != 3'd0);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         onesCnt        <= 4'd0;
         fill           <= 4'd0;
         delayLine      <= 8'h00;
         shiftReg       <= 8'h00;
         bitCnt         <= 3'd0;
         Rx_Data        <= 8'h00;
         Rx_DataValid   <= 1'b0;
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortSignal <= 1'b0;
         Rx_EndOfFrame  <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_ValidFrame  <= 1'b0;
      end else begin
         Rx_DataValid   <= byteDone;
         Rx_FlagDetect  <= flagNext;
         Rx_AbortSignal <= abortNext;
         Rx_EndOfFrame  <= eofNext;
         Rx_FrameError  <= errNext;
         Rx_ValidFrame  <= (stateNext == DATA);
         if (RxEN) begin
            onesCnt <= onesNext;
            if (isAbort || isFlag) begin
               fill      <= 4'd0;
               delayLine <= 8'h00;
            end else if (accept) begin
               delayLine <= {delayLine[6:0], Rx};
               fill      <= (fill == 4'd8) ? fill : fill + 4'd1;
            end
            if (dataBit) shiftReg <= {exitBit, shiftReg[7:1]};
            if (byteDone) Rx_Data <= {exitBit, shiftReg[7:1]};
            if (isAbort || isFlag) bitCnt <= 3'd0;
            else if (dataBit)      bitCnt <= bitCntAfter;
         end
      end
   end

endmodule
